// File: rtl/imc_readout_ctrl.sv
// Wishbone read sequencer for the IMC SA/OB readout mux: fires the sense amps, waits for the OB, registers data, acks.
// Optional OB_WAIT timeout (ERR_WORD response, sticky rd_err_o) is built when IMC_RD_TIMEOUT_EN is defined.
module imc_readout_ctrl #(
    parameter int unsigned SA_LAT   = 2,
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_WORD = 32'hDEAD_0B0B
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_adr_i,
    input  logic [31:0] mux_data_i,
    input  logic        ob_valid_i,
    output logic [2:0]  mux_sel_o,
    output logic        sa_en_o,
    output logic        ob_rd_done_o,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        busy_o,
    output logic        rd_err_o
);

    typedef enum logic [2:0] {
        IDLE,
        SA_FIRE,
        SA_WAIT,
        OB_WAIT,
        CAPTURE,
        ACK
    } state_t;

    localparam logic [2:0] SEL_IDLE  = 3'b000;
    localparam logic [2:0] SEL_OB_LO = 3'b001;
    localparam logic [2:0] SEL_OB_HI = 3'b010;
    localparam logic [2:0] SEL_SA    = 3'b100;

    localparam logic [3:0] SA_LOAD = 4'(SA_LAT - 1);

    state_t     state;
    logic [3:0] sa_cnt;
    logic       null_acc;
    logic       ob_hi;

    logic req;
    logic rd_sa;
    logic rd_ob_lo;
    logic rd_ob_hi;

    assign req      = wbs_cyc_i & wbs_stb_i;
    assign rd_sa    = !wbs_we_i && (wbs_adr_i == 4'h0);
    assign rd_ob_lo = !wbs_we_i && (wbs_adr_i == 4'h4);
    assign rd_ob_hi = !wbs_we_i && (wbs_adr_i == 4'h8);

`ifdef IMC_RD_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] to_cnt;
    logic       rd_err_q;

    assign rd_err_o = rd_err_q;
`else
    assign rd_err_o = 1'b0;
`endif

    // Writes and unmapped offsets pass through CAPTURE with null_acc set so they
    // return zero data one cycle later, never touching the mux or sense amps.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state        <= IDLE;
            sa_cnt       <= 4'd0;
            null_acc     <= 1'b0;
            ob_hi        <= 1'b0;
            mux_sel_o    <= SEL_IDLE;
            sa_en_o      <= 1'b0;
            ob_rd_done_o <= 1'b0;
            wbs_ack_o    <= 1'b0;
            wbs_dat_o    <= 32'd0;
            busy_o       <= 1'b0;
`ifdef IMC_RD_TIMEOUT_EN
            to_cnt       <= 8'd0;
            rd_err_q     <= 1'b0;
`endif
        end else begin
            sa_en_o      <= 1'b0;
            wbs_ack_o    <= 1'b0;
            ob_rd_done_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (req) begin
                        busy_o   <= 1'b1;
                        null_acc <= 1'b0;
                        ob_hi    <= 1'b0;
`ifdef IMC_RD_TIMEOUT_EN
                        to_cnt   <= 8'd0;
`endif
                        if (rd_sa) begin
                            state     <= SA_FIRE;
                            sa_en_o   <= 1'b1;
                            mux_sel_o <= SEL_SA;
                        end else if (rd_ob_lo) begin
                            state     <= OB_WAIT;
                            mux_sel_o <= SEL_OB_LO;
                        end else if (rd_ob_hi) begin
                            state     <= OB_WAIT;
                            mux_sel_o <= SEL_OB_HI;
                            ob_hi     <= 1'b1;
                        end else begin
                            state     <= CAPTURE;
                            null_acc  <= 1'b1;
                        end
                    end
                end

                SA_FIRE: begin
                    sa_cnt <= SA_LOAD;
                    state  <= SA_WAIT;
                end

                SA_WAIT: begin
                    if (!wbs_cyc_i) begin
                        state     <= IDLE;
                        busy_o    <= 1'b0;
                        mux_sel_o <= SEL_IDLE;
                    end else if (sa_cnt == 4'd0) begin
                        state <= CAPTURE;
                    end else begin
                        sa_cnt <= sa_cnt - 4'd1;
                    end
                end

                // ob_valid_i is only looked at from inside OB_WAIT, which gives the one-cycle minimum.
                OB_WAIT: begin
                    if (!wbs_cyc_i) begin
                        state     <= IDLE;
                        busy_o    <= 1'b0;
                        mux_sel_o <= SEL_IDLE;
                    end else if (ob_valid_i) begin
                        state <= CAPTURE;
`ifdef IMC_RD_TIMEOUT_EN
                    end else if (to_cnt == TO_LAST) begin
                        state     <= ACK;
                        wbs_ack_o <= 1'b1;
                        wbs_dat_o <= ERR_WORD;
                        mux_sel_o <= SEL_IDLE;
                        rd_err_q  <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
`endif
                    end
                end

                CAPTURE: begin
                    wbs_dat_o    <= null_acc ? 32'd0 : mux_data_i;
                    wbs_ack_o    <= 1'b1;
                    ob_rd_done_o <= ob_hi && !null_acc;
                    mux_sel_o    <= SEL_IDLE;
                    state        <= ACK;
                end

                ACK: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end

                default: begin
                    state     <= IDLE;
                    busy_o    <= 1'b0;
                    mux_sel_o <= SEL_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imc_readout_ctrl.sv
// Directed testbench for imc_readout_ctrl: SA read, OB pair, OB stall, write/unmapped, abort, reset, optional timeout.
module tb_imc_readout_ctrl;

    logic        wb_clk_i;
    logic        wb_rst_n;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_adr_i;
    logic [31:0] mux_data_i;
    logic        ob_valid_i;
    logic [2:0]  mux_sel_o;
    logic        sa_en_o;
    logic        ob_rd_done_o;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        busy_o;
    logic        rd_err_o;

    int checks;
    int failures;

    imc_readout_ctrl #(
        .SA_LAT   (2),
        .TIMEOUT  (255),
        .ERR_WORD (32'hDEAD_0B0B)
    ) dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_n     (wb_rst_n),
        .wbs_cyc_i    (wbs_cyc_i),
        .wbs_stb_i    (wbs_stb_i),
        .wbs_we_i     (wbs_we_i),
        .wbs_adr_i    (wbs_adr_i),
        .mux_data_i   (mux_data_i),
        .ob_valid_i   (ob_valid_i),
        .mux_sel_o    (mux_sel_o),
        .sa_en_o      (sa_en_o),
        .ob_rd_done_o (ob_rd_done_o),
        .wbs_ack_o    (wbs_ack_o),
        .wbs_dat_o    (wbs_dat_o),
        .busy_o       (busy_o),
        .rd_err_o     (rd_err_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    task automatic tick;
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic apply_stimulus(input logic cyc, input logic stb, input logic we, input logic [3:0] adr);
        wbs_cyc_i = cyc;
        wbs_stb_i = stb;
        wbs_we_i  = we;
        wbs_adr_i = adr;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_output({tag, "_sel"}, {29'd0, mux_sel_o}, 32'd0);
        check_bit({tag, "_sa_en"}, sa_en_o, 1'b0);
        check_bit({tag, "_done"}, ob_rd_done_o, 1'b0);
        check_bit({tag, "_ack"}, wbs_ack_o, 1'b0);
        check_bit({tag, "_busy"}, busy_o, 1'b0);
        check_bit({tag, "_err"}, rd_err_o, 1'b0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        wb_rst_n   = 1'b0;
        mux_data_i = 32'd0;
        ob_valid_i = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'h0);

        // Reset state
        tick;
        tick;
        check_quiet("reset");
        check_output("reset_dat", wbs_dat_o, 32'd0);
        wb_rst_n = 1'b1;
        tick;

        // SA read: sa_en in cycle 1, sel 100 in cycles 1-4, ack in cycle 5
        $display("[TB] SA read");
        mux_data_i = 32'h0000_A5C3;
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'h0);
        tick;
        check_bit("sa_c1_en", sa_en_o, 1'b1);
        check_output("sa_c1_sel", {29'd0, mux_sel_o}, 32'h4);
        check_bit("sa_c1_busy", busy_o, 1'b1);
        tick;
        check_bit("sa_c2_en", sa_en_o, 1'b0);
        check_output("sa_c2_sel", {29'd0, mux_sel_o}, 32'h4);
        tick;
        check_output("sa_c3_sel", {29'd0, mux_sel_o}, 32'h4);
        check_bit("sa_c3_ack", wbs_ack_o, 1'b0);
        tick;
        check_output("sa_c4_sel", {29'd0, mux_sel_o}, 32'h4);
        check_bit("sa_c4_ack", wbs_ack_o, 1'b0);
        tick;
        check_bit("sa_c5_ack", wbs_ack_o, 1'b1);
        check_output("sa_c5_dat", wbs_dat_o, 32'h0000_A5C3);
        check_output("sa_c5_sel", {29'd0, mux_sel_o}, 32'h0);
        check_bit("sa_c5_done", ob_rd_done_o, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'h0);
        tick;
        check_bit("sa_c6_ack", wbs_ack_o, 1'b0);
        check_bit("sa_c6_busy", busy_o, 1'b0);
        check_output("sa_c6_dat_hold", wbs_dat_o, 32'h0000_A5C3);

        // OB pair, back-to-back with strobe held across the first ack
        $display("[TB] OB pair");
        ob_valid_i = 1'b1;
        mux_data_i = 32'h1234_5678;
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'h4);
        tick;
        check_output("oblo_c1_sel", {29'd0, mux_sel_o}, 32'h1);
        tick;
        check_output("oblo_c2_sel", {29'd0, mux_sel_o}, 32'h1);
        check_bit("oblo_c2_ack", wbs_ack_o, 1'b0);
        tick;
        check_bit("oblo_c3_ack", wbs_ack_o, 1'b1);
        check_output("oblo_c3_dat", wbs_dat_o, 32'h1234_5678);
        check_bit("oblo_c3_done", ob_rd_done_o, 1'b0);
        mux_data_i = 32'h9ABC_DEF0;
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'h8);
        tick;
        check_bit("b2b_idle_busy", busy_o, 1'b0);
        check_bit("b2b_idle_ack", wbs_ack_o, 1'b0);
        tick;
        check_output("obhi_c1_sel", {29'd0, mux_sel_o}, 32'h2);
        check_bit("obhi_c1_busy", busy_o, 1'b1);
        tick;
        check_output("obhi_c2_sel", {29'd0, mux_sel_o}, 32'h2);
        check_bit("obhi_c2_done", ob_rd_done_o, 1'b0);
        tick;
        check_bit("obhi_c3_ack", wbs_ack_o, 1'b1);
        check_output("obhi_c3_dat", wbs_dat_o, 32'h9ABC_DEF0);
        check_bit("obhi_c3_done", ob_rd_done_o, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'h0);
        tick;
        check_bit("obhi_c4_done", ob_rd_done_o, 1'b0);
        check_bit("obhi_c4_ack", wbs_ack_o, 1'b0);

        // OB stall: ten cycles without valid, ack two cycles after valid is sampled
        $display("[TB] OB stall");
        ob_valid_i = 1'b0;
        mux_data_i = 32'h5555_AAAA;
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'h4);
        for (int i = 0; i < 10; i++) begin
            tick;
            check_bit("stall_busy", busy_o, 1'b1);
            check_bit("stall_ack", wbs_ack_o, 1'b0);
        end
        ob_valid_i = 1'b1;
        tick;
        check_bit("stall_cap_ack", wbs_ack_o, 1'b0);
        check_bit("stall_cap_busy", busy_o, 1'b1);
        tick;
        check_bit("stall_ack_hi", wbs_ack_o, 1'b1);
        check_output("stall_dat", wbs_dat_o, 32'h5555_AAAA);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'h0);
        tick;

        // Write to 0x0: zero data, ack in cycle 2, no sense-amp fire
        $display("[TB] write and unmapped");
        apply_stimulus(1'b1, 1'b1, 1'b1, 4'h0);
        tick;
        check_bit("wr_c1_ack", wbs_ack_o, 1'b0);
        check_bit("wr_c1_sa_en", sa_en_o, 1'b0);
        check_output("wr_c1_sel", {29'd0, mux_sel_o}, 32'h0);
        tick;
        check_bit("wr_c2_ack", wbs_ack_o, 1'b1);
        check_output("wr_c2_dat", wbs_dat_o, 32'd0);
        check_output("wr_c2_sel", {29'd0, mux_sel_o}, 32'h0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'h0);
        tick;

        // Unmapped read at 0xC after loading nonzero data
        mux_data_i = 32'hCAFE_F00D;
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'h4);
        tick;
        tick;
        tick;
        check_output("pre_unmap_dat", wbs_dat_o, 32'hCAFE_F00D);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'h0);
        tick;
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'hC);
        tick;
        check_bit("unmap_c1_ack", wbs_ack_o, 1'b0);
        check_bit("unmap_c1_sa_en", sa_en_o, 1'b0);
        check_output("unmap_c1_sel", {29'd0, mux_sel_o}, 32'h0);
        tick;
        check_bit("unmap_c2_ack", wbs_ack_o, 1'b1);
        check_output("unmap_c2_dat", wbs_dat_o, 32'd0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'h0);
        tick;

        // Abort in SA_WAIT: cyc dropped, no ack afterwards
        $display("[TB] abort");
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'h0);
        tick;
        tick;
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'h0);
        tick;
        check_bit("abort_busy", busy_o, 1'b0);
        check_output("abort_sel", {29'd0, mux_sel_o}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick;
            check_bit("abort_no_ack", wbs_ack_o, 1'b0);
        end

        // Abort in OB_WAIT: no ack, no done pulse
        ob_valid_i = 1'b0;
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'h8);
        tick;
        tick;
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'h0);
        ob_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            check_bit("obabort_no_ack", wbs_ack_o, 1'b0);
            check_bit("obabort_no_done", ob_rd_done_o, 1'b0);
        end

        // Reset asserted mid-SA_WAIT
        $display("[TB] reset mid-read");
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'h0);
        tick;
        tick;
        check_bit("rst_pre_busy", busy_o, 1'b1);
        wb_rst_n = 1'b0;
        #1;
        check_quiet("rst_mid");
        check_output("rst_mid_dat", wbs_dat_o, 32'd0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'h0);
        tick;
        wb_rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick;
            check_bit("rst_no_ack", wbs_ack_o, 1'b0);
            check_bit("rst_idle", busy_o, 1'b0);
        end

`ifdef IMC_RD_TIMEOUT_EN
        // Timeout: 255 cycles in OB_WAIT, ack with ERR_WORD in cycle 256
        $display("[TB] timeout");
        ob_valid_i = 1'b0;
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'h8);
        repeat (255) tick;
        check_bit("to_c255_ack", wbs_ack_o, 1'b0);
        check_bit("to_c255_err", rd_err_o, 1'b0);
        tick;
        check_bit("to_ack", wbs_ack_o, 1'b1);
        check_output("to_dat", wbs_dat_o, 32'hDEAD_0B0B);
        check_bit("to_done", ob_rd_done_o, 1'b0);
        check_bit("to_err", rd_err_o, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'h0);
        tick;
        ob_valid_i = 1'b1;
        mux_data_i = 32'h0F0F_1234;
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'h4);
        tick;
        tick;
        tick;
        check_bit("to_good_ack", wbs_ack_o, 1'b1);
        check_output("to_good_dat", wbs_dat_o, 32'h0F0F_1234);
        check_bit("to_err_sticky", rd_err_o, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'h0);
        tick;
`else
        check_bit("no_timeout_err", rd_err_o, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
